// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 1101 sequence detector and the match framer
// that sits downstream of it.
//   - frm_state_t : framer states (IDLE, RUN)
//   - S0..S3      : detector state encodings
//   - sat_inc     : saturating increment helper
// ---------------------------------------------------------------------------
package seq_pkg;

    // Framer FSM states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } frm_state_t;

    // Upstream 1101 Mealy detector states (number of pattern bits seen)
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    // Returns value+1, or value unchanged once it has reached max_value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/seq_result_slot.sv
// ---------------------------------------------------------------------------
// seq_result_slot
// One-entry valid/ready holding register for frame results.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : a frame result is offered this cycle
//   load_count/found/first_idx : the offered result
//   res_ready       : consumer accepts the held result
//   res_valid/count/found/first_idx : held result (registered)
//   overrun         : sticky, set when an offered result is dropped
//   overrun_clr     : clears overrun (set wins when simultaneous)
// ---------------------------------------------------------------------------
module seq_result_slot #(
    parameter int CNT_W = 8,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    input  logic             load_found,
    input  logic [IDX_W-1:0] load_first_idx,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_count,
    output logic             res_found,
    output logic [IDX_W-1:0] res_first_idx,
    output logic             overrun,
    input  logic             overrun_clr
);

    logic xfer;
    logic accept;
    logic drop;

    // A result can enter when the slot is empty or is being drained this
    // very cycle; otherwise it is lost and the held result stays intact.
    assign xfer   = res_valid & res_ready;
    assign accept = load & (~res_valid | xfer);
    assign drop   = load & res_valid & ~res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid     <= 1'b0;
            res_count     <= '0;
            res_found     <= 1'b0;
            res_first_idx <= '0;
        end else if (accept) begin
            res_valid     <= 1'b1;
            res_count     <= load_count;
            res_found     <= load_found;
            res_first_idx <= load_first_idx;
        end else if (xfer) begin
            res_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_match_framer.sv
// ---------------------------------------------------------------------------
// seq_match_framer
// Groups the detector's match pulses into frames of FRAME_LEN bit-cycles,
// counting matches and noting the index of the first one, and publishes
// each frame's result through a one-entry valid/ready slot.
//   clk, rst      : clock, asynchronous active-high reset
//   bit_en        : qualifies a bit-cycle
//   y_in          : match pulse from the detector
//   frame_start   : synchronous (re)start of framing
//   res_valid/res_ready : result handshake
//   res_count, res_found, res_first_idx : published frame result
//   overrun, overrun_clr : sticky dropped-result flag and its clear
// ---------------------------------------------------------------------------
module seq_match_framer
    import seq_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             y_in,
    input  logic             frame_start,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_found,
    output logic [IDX_W-1:0] res_first_idx,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [31:0]      CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

    frm_state_t       state_reg, state_next;
    logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic [CNT_W-1:0] acc_cnt_reg, acc_cnt_next;
    logic             acc_found_reg, acc_found_next;
    logic [IDX_W-1:0] acc_first_reg, acc_first_next;

    logic             running;
    logic             frame_end;
    logic             restart;
    logic             sample;
    logic [IDX_W-1:0] base_idx;
    logic [CNT_W-1:0] base_cnt;
    logic             base_found;
    logic [IDX_W-1:0] base_first;
    logic [CNT_W-1:0] upd_cnt;
    logic             upd_found;
    logic [IDX_W-1:0] upd_first;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        if (frame_start) begin
            state_next = RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        running = (state_reg == RUN);
    end

    // ---------------- Frame accumulation ----------------
    // A frame end wins over frame_start in the same cycle: the last bit is
    // counted into the finishing frame and the wrap already yields a clean
    // restart, so frame_start has nothing left to do.
    assign frame_end = running & bit_en & (bit_idx_reg == LAST_IDX);
    assign restart   = frame_start & ~frame_end;
    assign sample    = bit_en & (running | frame_start);

    // On restart the current bit is index 0 of a fresh frame, so it must be
    // folded into zeroed accumulators rather than the aborted ones.
    always_comb begin
        base_idx   = restart ? '0 : bit_idx_reg;
        base_cnt   = restart ? '0 : acc_cnt_reg;
        base_found = restart ? 1'b0 : acc_found_reg;
        base_first = restart ? '0 : acc_first_reg;

        upd_cnt    = y_in ? CNT_W'(sat_inc(32'(base_cnt), CNT_MAX)) : base_cnt;
        upd_found  = base_found | y_in;
        upd_first  = (y_in & ~base_found) ? base_idx : base_first;
    end

    always_comb begin
        bit_idx_next   = bit_idx_reg;
        acc_cnt_next   = acc_cnt_reg;
        acc_found_next = acc_found_reg;
        acc_first_next = acc_first_reg;
        if (frame_end) begin
            bit_idx_next   = '0;
            acc_cnt_next   = '0;
            acc_found_next = 1'b0;
            acc_first_next = '0;
        end else if (sample) begin
            bit_idx_next   = base_idx + IDX_W'(1);
            acc_cnt_next   = upd_cnt;
            acc_found_next = upd_found;
            acc_first_next = upd_first;
        end else if (restart) begin
            bit_idx_next   = '0;
            acc_cnt_next   = '0;
            acc_found_next = 1'b0;
            acc_first_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_reg   <= '0;
            acc_cnt_reg   <= '0;
            acc_found_reg <= 1'b0;
            acc_first_reg <= '0;
        end else begin
            bit_idx_reg   <= bit_idx_next;
            acc_cnt_reg   <= acc_cnt_next;
            acc_found_reg <= acc_found_next;
            acc_first_reg <= acc_first_next;
        end
    end

    // ---------------- Output slot ----------------
    seq_result_slot #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_slot (
        .clk            (clk),
        .rst            (rst),
        .load           (frame_end),
        .load_count     (upd_cnt),
        .load_found     (upd_found),
        .load_first_idx (upd_first),
        .res_ready      (res_ready),
        .res_valid      (res_valid),
        .res_count      (res_count),
        .res_found      (res_found),
        .res_first_idx  (res_first_idx),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
    );

endmodule

// File: tb/tb_seq_match_framer.sv
module tb_seq_match_framer;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 2;
    localparam int IDX_W     = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_en = 1'b0;
    logic             y_in = 1'b0;
    logic             frame_start = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [CNT_W-1:0] res_count;
    logic             res_found;
    logic [IDX_W-1:0] res_first_idx;
    logic             overrun;
    logic             overrun_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    seq_match_framer #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_en        (bit_en),
        .y_in          (y_in),
        .frame_start   (frame_start),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_count     (res_count),
        .res_found     (res_found),
        .res_first_idx (res_first_idx),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic chk_result(input string tag, input logic v, input logic [CNT_W-1:0] c,
                              input logic f, input logic [IDX_W-1:0] i);
        chk({tag, ".valid"}, 32'(res_valid), 32'(v));
        chk({tag, ".count"}, 32'(res_count), 32'(c));
        chk({tag, ".found"}, 32'(res_found), 32'(f));
        chk({tag, ".first"}, 32'(res_first_idx), 32'(i));
    endtask

    // One full frame of bit_en=1 cycles; ymask[i] is y_in at index i.
    task automatic run_frame(input logic [7:0] ymask, input logic start);
        for (int i = 0; i < FRAME_LEN; i++) begin
            bit_en      = 1'b1;
            frame_start = start && (i == 0);
            y_in        = ymask[i];
            step();
        end
        frame_start = 1'b0;
        y_in        = 1'b0;
    endtask

    // One idle (bit_en=0) clock, used to let the consumer drain the slot.
    task automatic idle_cycle();
        bit_en = 1'b0;
        y_in   = 1'b0;
        step();
    endtask

    initial begin
        // ---- reset state ----
        rst = 1'b1;
        step();
        step();
        chk_result("reset", 1'b0, 2'd0, 1'b0, 3'd0);
        chk("reset.overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        step();

        // ---- 1: matches at idx 2 and 6 ----
        for (int i = 0; i < 7; i++) begin
            bit_en      = 1'b1;
            frame_start = (i == 0);
            y_in        = (i == 2) || (i == 6);
            step();
        end
        frame_start = 1'b0;
        chk("t1.pre_valid", 32'(res_valid), 32'd0);
        y_in = 1'b0;
        step();                                   // idx 7
        chk_result("t1", 1'b1, 2'd2, 1'b1, 3'd2);
        idle_cycle();
        chk("t1.drop", 32'(res_valid), 32'd0);

        // ---- 2: five matches saturate the 2-bit counter ----
        run_frame(8'b1001_1011, 1'b0);
        chk_result("t2", 1'b1, 2'd3, 1'b1, 3'd0);
        // last bit alone must be reported
        run_frame(8'b1000_0000, 1'b0);
        chk_result("t2.last", 1'b1, 2'd1, 1'b1, 3'd7);
        idle_cycle();

        // ---- 3: back-pressure and overrun ----
        res_ready = 1'b0;
        run_frame(8'b0000_1000, 1'b0);            // frame A: 1 match at 3
        chk_result("t3.A", 1'b1, 2'd1, 1'b1, 3'd3);
        chk("t3.ovr0", 32'(overrun), 32'd0);
        run_frame(8'b0010_0010, 1'b0);            // frame B: dropped
        chk_result("t3.hold", 1'b1, 2'd1, 1'b1, 3'd3);
        chk("t3.ovr1", 32'(overrun), 32'd1);
        res_ready = 1'b1;
        idle_cycle();
        chk("t3.xfer", 32'(res_valid), 32'd0);
        chk("t3.ovr_hold", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("t3.ovr_clr", 32'(overrun), 32'd0);

        // ---- 4: abort at idx 5 after matches at 1,3 ----
        for (int i = 0; i < 5; i++) begin
            bit_en = 1'b1;
            y_in   = (i == 1) || (i == 3);
            step();
        end
        run_frame(8'b0000_0001, 1'b1);            // restart; match at new idx 0
        chk_result("t4", 1'b1, 2'd1, 1'b1, 3'd0);
        idle_cycle();
        chk("t4.drain", 32'(res_valid), 32'd0);

        // ---- 5: bit_en toggling, y_in only on disabled cycles ----
        for (int c = 0; c < 16; c++) begin
            bit_en = (c % 2) == 1;
            y_in   = (c % 2) == 0;
            step();
            if (c == 14) chk("t5.pre_valid", 32'(res_valid), 32'd0);
        end
        chk_result("t5", 1'b1, 2'd0, 1'b0, 3'd0);
        idle_cycle();

        // ---- 6: asynchronous reset mid-frame with a held result ----
        res_ready = 1'b0;
        run_frame(8'b0000_0100, 1'b0);
        run_frame(8'b0000_0000, 1'b0);            // dropped -> overrun set
        chk_result("t6.held", 1'b1, 2'd1, 1'b1, 3'd2);
        chk("t6.ovr", 32'(overrun), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bit_en = 1'b1;
            y_in   = 1'b1;
            step();
        end
        #2;
        rst = 1'b1;
        #1;                                       // still before the next edge
        chk_result("t6.rst", 1'b0, 2'd0, 1'b0, 3'd0);
        chk("t6.rst_ovr", 32'(overrun), 32'd0);
        step();
        rst       = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin        // IDLE ignores y_in
            bit_en = 1'b1;
            y_in   = 1'b1;
            step();
        end
        chk("t6.idle", 32'(res_valid), 32'd0);
        run_frame(8'b0100_0000, 1'b1);
        chk_result("t6.after", 1'b1, 2'd1, 1'b1, 3'd6);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
